// File: rtl/alt_vipitc121_common_trigger_arbiter.sv
// Round-robin arbiter that lets NUM_REQ requesters share one clock-crossing trigger
// channel: grant, one trigger pulse, wait for ack (or time out), report done.
module alt_vipitc121_common_trigger_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int TIMEOUT = 255
) (
   input  logic               clock,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] grant,
   output logic               trigger_out,
   input  logic               ack_in,
   output logic [NUM_REQ-1:0] done,
   output logic               timeout_err,
   output logic               busy
);

   localparam int PTR_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_ISSUE    = 2'd1;
   localparam logic [1:0] S_WAIT_ACK = 2'd2;
   localparam logic [1:0] S_COMPLETE = 2'd3;

   logic [1:0]         state_q, state_d;
   logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [PTR_W-1:0]   idx_q, idx_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [NUM_REQ-1:0] done_q, done_d;
   logic               trig_q, trig_d;
   logic               tout_q, tout_d;
   logic               busy_q, busy_d;

   logic               sel_found;
   logic [PTR_W-1:0]   sel_idx;
   logic [PTR_W-1:0]   cand;

   // First asserted request at or above rr_ptr, wrapping around
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      cand      = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = PTR_W'((int'(rr_ptr_q) + i) % NUM_REQ);
         if (!sel_found && req[cand]) begin
            sel_found = 1'b1;
            sel_idx   = cand;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      grant_d  = grant_q;
      done_d   = '0;
      trig_d   = 1'b0;
      tout_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (sel_found) begin
               state_d = S_ISSUE;
               idx_d   = sel_idx;
               grant_d = NUM_REQ'(1) << sel_idx;
               trig_d  = 1'b1;
            end
         end
         S_ISSUE: begin
            state_d = S_WAIT_ACK;
            cnt_d   = '0;
         end
         S_WAIT_ACK: begin
            // An ack on the final counter value still counts as success
            if (ack_in) begin
               state_d = S_COMPLETE;
               done_d  = grant_q;
            end else if (cnt_q == CNT_MAX) begin
               state_d = S_COMPLETE;
               tout_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d  = S_IDLE;
            grant_d  = '0;
            rr_ptr_d = (idx_q == PTR_W'(NUM_REQ - 1)) ? '0 : idx_q + PTR_W'(1);
         end
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clock) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         rr_ptr_q <= '0;
         idx_q    <= '0;
         cnt_q    <= '0;
         grant_q  <= '0;
         done_q   <= '0;
         trig_q   <= 1'b0;
         tout_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         idx_q    <= idx_d;
         cnt_q    <= cnt_d;
         grant_q  <= grant_d;
         done_q   <= done_d;
         trig_q   <= trig_d;
         tout_q   <= tout_d;
         busy_q   <= busy_d;
      end
   end

   assign grant       = grant_q;
   assign done        = done_q;
   assign trigger_out = trig_q;
   assign timeout_err = tout_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_alt_vipitc121_common_trigger_arbiter.sv
// Directed bench for the trigger arbiter: a scoreboard queue holds the expected
// trigger/done/timeout events, cycle-exact checks are made inline by the stimulus.
module tb_alt_vipitc121_common_trigger_arbiter;

   localparam int N = 4;
   localparam logic [1:0] K_TRIG = 2'd0;
   localparam logic [1:0] K_DONE = 2'd1;
   localparam logic [1:0] K_TOUT = 2'd2;

   typedef struct packed {
      logic [1:0]   kind;
      logic [N-1:0] val;
   } exp_t;

   logic         clock = 1'b0;
   logic         rst_n = 1'b0;
   logic [N-1:0] req = '0;
   logic         ack_in = 1'b0;
   logic [N-1:0] grant;
   logic         trigger_out;
   logic [N-1:0] done;
   logic         timeout_err;
   logic         busy;

   exp_t sb_q[$];
   int   n_chk = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   last_trig = 0;

   alt_vipitc121_common_trigger_arbiter #(.NUM_REQ(N), .TIMEOUT(3)) dut (
      .clock      (clock),
      .rst_n      (rst_n),
      .req        (req),
      .grant      (grant),
      .trigger_out(trigger_out),
      .ack_in     (ack_in),
      .done       (done),
      .timeout_err(timeout_err),
      .busy       (busy)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push(input logic [1:0] kind, input logic [N-1:0] val);
      sb_q.push_back('{kind: kind, val: val});
   endtask

   task automatic sb_pop(input logic [1:0] kind, input logic [N-1:0] val);
      exp_t e;
      n_chk++;
      if (sb_q.size() == 0) begin
         n_fail++;
         $display("FAIL sb_unexpected: kind %0d value %b with nothing expected (t=%0t)", kind, val, $time);
      end else begin
         e = sb_q.pop_front();
         if (e.kind != kind || e.val != val) begin
            n_fail++;
            $display("FAIL sb_event: got kind %0d value %b expected kind %0d value %b (t=%0t)",
                     kind, val, e.kind, e.val, $time);
         end
      end
   endtask

   // Monitor: every presented event must match the head of the scoreboard
   always @(negedge clock) begin
      if (rst_n === 1'b1) begin
         if (trigger_out === 1'b1) sb_pop(K_TRIG, grant);
         if (|done) sb_pop(K_DONE, done);
         if (timeout_err === 1'b1) sb_pop(K_TOUT, '0);
      end
   end

   task automatic do_reset();
      rst_n = 1'b0;
      req = '0;
      ack_in = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, got running expected finished");
      $fatal(1);
   end

   initial begin
      // Reset state
      tick();
      do_reset();
      chk("rst_grant", 32'(grant), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_trig", 32'(trigger_out), 0);
      chk("rst_tout", 32'(timeout_err), 0);
      chk("rst_busy", 32'(busy), 0);

      // Single requester; req changes mid-transaction must not matter
      req = 4'b0100;
      push(K_TRIG, 4'b0100);
      tick();
      chk("single_trig", 32'(trigger_out), 1);
      chk("single_grant", 32'(grant), 32'b0100);
      chk("single_busy", 32'(busy), 1);
      tick();
      chk("single_trig_off", 32'(trigger_out), 0);
      req = 4'b1011;
      tick();
      chk("single_grant_hold", 32'(grant), 32'b0100);
      chk("single_no_done", 32'(done), 0);
      ack_in = 1'b1;
      push(K_DONE, 4'b0100);
      tick();
      chk("single_done", 32'(done), 32'b0100);
      chk("single_done_tout", 32'(timeout_err), 0);
      ack_in = 1'b0;
      req = '0;
      tick();
      chk("single_grant_clr", 32'(grant), 0);
      chk("single_done_clr", 32'(done), 0);
      chk("single_busy_clr", 32'(busy), 0);

      // Round-robin from requester 0 after reset
      do_reset();
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         logic [N-1:0] eg;
         eg = N'(1) << (k % N);
         push(K_TRIG, eg);
         tick();
         chk("rr_trig", 32'(trigger_out), 1);
         chk("rr_grant", 32'(grant), 32'(eg));
         if (k > 0) chk("rr_spacing", cyc - last_trig, 4);
         last_trig = cyc;
         tick();
         ack_in = 1'b1;
         push(K_DONE, eg);
         tick();
         chk("rr_done", 32'(done), 32'(eg));
         ack_in = 1'b0;
         tick();
         chk("rr_idle_grant", 32'(grant), 0);
         chk("rr_idle_trig", 32'(trigger_out), 0);
      end
      req = '0;

      // Timeout with TIMEOUT=3, next grant goes to requester 1
      do_reset();
      req = 4'b0011;
      push(K_TRIG, 4'b0001);
      tick();
      chk("to_grant", 32'(grant), 32'b0001);
      for (int c = 0; c < 4; c++) begin
         tick();
         chk("to_wait_tout", 32'(timeout_err), 0);
         chk("to_wait_busy", 32'(busy), 1);
      end
      push(K_TOUT, '0);
      tick();
      chk("to_pulse", 32'(timeout_err), 1);
      chk("to_done", 32'(done), 0);
      tick();
      chk("to_pulse_clr", 32'(timeout_err), 0);
      chk("to_grant_clr", 32'(grant), 0);
      push(K_TRIG, 4'b0010);
      tick();
      chk("to_next_grant", 32'(grant), 32'b0010);
      tick();
      ack_in = 1'b1;
      push(K_DONE, 4'b0010);
      tick();
      chk("to_next_done", 32'(done), 32'b0010);
      ack_in = 1'b0;
      req = '0;
      tick();

      // Ack on the same cycle the counter reaches TIMEOUT
      do_reset();
      req = 4'b0001;
      push(K_TRIG, 4'b0001);
      tick();
      repeat (4) tick();
      ack_in = 1'b1;
      push(K_DONE, 4'b0001);
      tick();
      chk("sim_done", 32'(done), 32'b0001);
      chk("sim_tout", 32'(timeout_err), 0);
      ack_in = 1'b0;
      req = '0;
      tick();

      // Reset during WAIT_ACK abandons the transaction
      req = 4'b0010;
      push(K_TRIG, 4'b0010);
      tick();
      tick();
      chk("mid_grant", 32'(grant), 32'b0010);
      rst_n = 1'b0;
      tick();
      chk("mid_rst_grant", 32'(grant), 0);
      chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_done", 32'(done), 0);
      chk("mid_rst_tout", 32'(timeout_err), 0);
      rst_n = 1'b1;
      push(K_TRIG, 4'b0010);
      tick();
      chk("mid_regrant", 32'(grant), 32'b0010);
      chk("mid_retrig", 32'(trigger_out), 1);
      tick();
      ack_in = 1'b1;
      push(K_DONE, 4'b0010);
      tick();
      chk("mid_done", 32'(done), 32'b0010);
      ack_in = 1'b0;
      req = '0;
      tick();

      // Stray acks in IDLE, ISSUE and COMPLETE are ignored
      ack_in = 1'b1;
      tick();
      ack_in = 1'b0;
      chk("stray_idle_done", 32'(done), 0);
      chk("stray_idle_busy", 32'(busy), 0);
      req = 4'b0001;
      push(K_TRIG, 4'b0001);
      tick();
      ack_in = 1'b1;
      tick();
      ack_in = 1'b0;
      chk("stray_issue_done", 32'(done), 0);
      chk("stray_grant", 32'(grant), 32'b0001);
      tick();
      chk("stray_wait_done", 32'(done), 0);
      ack_in = 1'b1;
      push(K_DONE, 4'b0001);
      tick();
      chk("stray_fresh_done", 32'(done), 32'b0001);
      tick();
      chk("stray_complete_done", 32'(done), 0);
      chk("stray_complete_busy", 32'(busy), 0);
      ack_in = 1'b0;
      req = '0;
      tick();
      tick();

      chk("sb_empty", sb_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
